// File: rtl/sync_w2r_level_if.sv
// rtl/sync_w2r_level_if.sv - write-to-read pointer sync bundle (pointer inputs, level/flag outputs)
interface sync_w2r_level_if #(
  parameter int ADDR_SIZE = 3
);
  logic [ADDR_SIZE:0] write_pointer;
  logic [ADDR_SIZE:0] read_pointer_bin;
  logic [ADDR_SIZE:0] read_to_write_pointer;
  logic [ADDR_SIZE:0] write_pointer_bin;
  logic [ADDR_SIZE:0] fill_level;
  logic               read_empty;
  logic               read_almost_empty;
  logic               write_advance;
  logic               sync_error;

  modport master (
    output write_pointer,
    output read_pointer_bin,
    input  read_to_write_pointer,
    input  write_pointer_bin,
    input  fill_level,
    input  read_empty,
    input  read_almost_empty,
    input  write_advance,
    input  sync_error
  );

  modport slave (
    input  write_pointer,
    input  read_pointer_bin,
    output read_to_write_pointer,
    output write_pointer_bin,
    output fill_level,
    output read_empty,
    output read_almost_empty,
    output write_advance,
    output sync_error
  );
endinterface

// File: rtl/sync_w2r_level.sv
// rtl/sync_w2r_level.sv - gray write pointer sync into read domain with fill level and flags
// Optional pointer-integrity checker built when SYNC_W2R_CHECK_EN is defined.
module sync_w2r_level #(
  parameter int ADDR_SIZE           = 3,
  parameter int SYNC_STAGES         = 2,
  parameter int ALMOST_EMPTY_THRESH = 1
) (
  input  logic             read_clk,
  input  logic             read_reset_n,
  sync_w2r_level_if.slave  bus
);
  localparam int PW = ADDR_SIZE + 1;
  localparam logic [PW-1:0] AE_THRESH = PW'(ALMOST_EMPTY_THRESH);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_stages
    $error("sync_w2r_level: SYNC_STAGES must be in 2..4");
  end

  logic [PW-1:0] sync_stage [SYNC_STAGES];
  logic [PW-1:0] synced_gray;
  logic [PW-1:0] synced_bin;
  logic [PW-1:0] write_pointer_bin_q;
  logic          write_advance_q;
  logic [PW-1:0] fill_level;

  function automatic logic [PW-1:0] gray_to_bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b = '0;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Plain flop pipeline: nothing may sit between write_pointer and stage 0.
  always_ff @(posedge read_clk or negedge read_reset_n) begin
    if (!read_reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_stage[i] <= '0;
      end
    end else begin
      sync_stage[0] <= bus.write_pointer;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_stage[i] <= sync_stage[i-1];
      end
    end
  end

  assign synced_gray = sync_stage[SYNC_STAGES-1];
  assign synced_bin  = gray_to_bin(synced_gray);

  always_ff @(posedge read_clk or negedge read_reset_n) begin
    if (!read_reset_n) begin
      write_pointer_bin_q <= '0;
      write_advance_q     <= 1'b0;
    end else begin
      write_pointer_bin_q <= synced_bin;
      write_advance_q     <= (synced_bin != write_pointer_bin_q);
    end
  end

  // Read side is live, write side is delayed: flags err towards empty.
  assign fill_level = write_pointer_bin_q - bus.read_pointer_bin;

  assign bus.read_to_write_pointer = synced_gray;
  assign bus.write_pointer_bin     = write_pointer_bin_q;
  assign bus.fill_level            = fill_level;
  assign bus.read_empty            = (fill_level == '0);
  assign bus.read_almost_empty     = (fill_level <= AE_THRESH);
  assign bus.write_advance         = write_advance_q;

`ifdef SYNC_W2R_CHECK_EN
  localparam logic [PW-1:0] DEPTH = {1'b1, {ADDR_SIZE{1'b0}}};

  logic [PW-1:0] prev_synced_gray;
  logic          sync_error_q;

  // A legal gray pointer moves one bit per update; fill can never exceed depth.
  always_ff @(posedge read_clk or negedge read_reset_n) begin
    if (!read_reset_n) begin
      prev_synced_gray <= '0;
      sync_error_q     <= 1'b0;
    end else begin
      prev_synced_gray <= synced_gray;
      if (($countones(synced_gray ^ prev_synced_gray) > 1) || (fill_level > DEPTH)) begin
        sync_error_q <= 1'b1;
      end
    end
  end

  assign bus.sync_error = sync_error_q;
`else
  assign bus.sync_error = 1'b0;
`endif

endmodule

// File: tb/tb_sync_w2r_level.sv
// tb/tb_sync_w2r_level.sv - directed bench for sync_w2r_level against a delay-line model
module tb_sync_w2r_level;
  logic read_clk;
  logic read_reset_n;
  int   tests_run;
  int   tests_failed;
  bit   cmp_en;

  sync_w2r_level_if #(.ADDR_SIZE(3)) bus ();

  sync_w2r_level #(
    .ADDR_SIZE(3),
    .SYNC_STAGES(2),
    .ALMOST_EMPTY_THRESH(1)
  ) dut (
    .read_clk(read_clk),
    .read_reset_n(read_reset_n),
    .bus(bus)
  );

  initial begin
    read_clk = 1'b0;
    forever #5 read_clk = ~read_clk;
  end

  // Model: remember the write pointer seen at each of the last four edges.
  // q[3] newest. Synced gray is 2 edges old, binary is 3 edges old.
  logic [3:0] q [4];
  bit         m_err;
  logic [3:0] m_rtw, m_wpb, m_prev_wpb, m_fill;

  function automatic logic [3:0] g2b(input logic [3:0] g);
    return g ^ (g >> 1) ^ (g >> 2) ^ (g >> 3);
  endfunction

  assign m_rtw      = q[2];
  assign m_wpb      = g2b(q[1]);
  assign m_prev_wpb = g2b(q[0]);
  assign m_fill     = m_wpb - bus.read_pointer_bin;

  always @(posedge read_clk or negedge read_reset_n) begin
    if (!read_reset_n) begin
      for (int i = 0; i < 4; i++) q[i] = 4'd0;
      m_err = 1'b0;
    end else begin
`ifdef SYNC_W2R_CHECK_EN
      if ($countones(q[2] ^ q[1]) > 1 || m_fill > 4'd8) m_err = 1'b1;
`endif
      q[0] = q[1];
      q[1] = q[2];
      q[2] = q[3];
      q[3] = bus.write_pointer;
    end
  end

  task automatic chk4(input string name, input logic [3:0] act, input logic [3:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge read_clk) begin
    if (cmp_en) begin
      chk4("cyc_rtw", bus.read_to_write_pointer, m_rtw);
      chk4("cyc_wpb", bus.write_pointer_bin, m_wpb);
      chk4("cyc_fill", bus.fill_level, m_fill);
      chk1("cyc_empty", bus.read_empty, m_fill == 4'd0);
      chk1("cyc_aempty", bus.read_almost_empty, m_fill <= 4'd1);
      chk1("cyc_adv", bus.write_advance, m_wpb != m_prev_wpb);
      chk1("cyc_err", bus.sync_error, m_err);
    end
  end

  task automatic tick();
    @(posedge read_clk);
    #3;
  endtask

  task automatic chk_cleared(input string tag);
    chk4({tag, "_rtw"}, bus.read_to_write_pointer, 4'd0);
    chk4({tag, "_wpb"}, bus.write_pointer_bin, 4'd0);
    chk4({tag, "_fill"}, bus.fill_level, 4'd0);
    chk1({tag, "_empty"}, bus.read_empty, 1'b1);
    chk1({tag, "_aempty"}, bus.read_almost_empty, 1'b1);
    chk1({tag, "_adv"}, bus.write_advance, 1'b0);
    chk1({tag, "_err"}, bus.sync_error, 1'b0);
  endtask

  logic [3:0] b4;
  logic       exp_err;

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    cmp_en       = 1'b0;
    bus.write_pointer    = 4'd0;
    bus.read_pointer_bin = 4'd0;
    read_reset_n = 1'b1;
    #1 read_reset_n = 1'b0;
    cmp_en = 1'b1;
    tick();
    tick();
    chk_cleared("reset");
    read_reset_n = 1'b1;
    tick();

    // First write: gray 0001 sampled at edge k
    bus.write_pointer = 4'b0001;
    tick();
    chk4("w1_rtw_k", bus.read_to_write_pointer, 4'b0000);
    tick();
    chk4("w1_rtw_k1", bus.read_to_write_pointer, 4'b0001);
    chk4("w1_wpb_k1", bus.write_pointer_bin, 4'd0);
    tick();
    chk4("w1_wpb_k2", bus.write_pointer_bin, 4'd1);
    chk1("w1_adv_k2", bus.write_advance, 1'b1);
    chk4("w1_fill", bus.fill_level, 4'd1);
    chk1("w1_empty", bus.read_empty, 1'b0);
    chk1("w1_aempty", bus.read_almost_empty, 1'b1);
    tick();
    chk1("w1_adv_k3", bus.write_advance, 1'b0);

    // Write to binary 3, then drain with same-cycle read pointer steps
    bus.write_pointer = 4'b0011;
    tick();
    bus.write_pointer = 4'b0010;
    repeat (3) tick();
    chk4("d_wpb", bus.write_pointer_bin, 4'd3);
    chk4("d_fill3", bus.fill_level, 4'd3);
    chk1("d_aempty3", bus.read_almost_empty, 1'b0);
    bus.read_pointer_bin = 4'd1;
    #1 chk4("d_fill2", bus.fill_level, 4'd2);
    bus.read_pointer_bin = 4'd2;
    #1 chk4("d_fill1", bus.fill_level, 4'd1);
    chk1("d_aempty1", bus.read_almost_empty, 1'b1);
    bus.read_pointer_bin = 4'd3;
    #1 chk4("d_fill0", bus.fill_level, 4'd0);
    chk1("d_empty0", bus.read_empty, 1'b1);
    tick();

    // Walk the write pointer up to 15 while reads trail, then wrap to 0
    for (int b = 4; b <= 15; b++) begin
      b4 = 4'(b);
      bus.write_pointer    = b4 ^ (b4 >> 1);
      bus.read_pointer_bin = (b >= 7) ? 4'(b - 4) : 4'd3;
      tick();
    end
    bus.write_pointer    = 4'b0000;
    bus.read_pointer_bin = 4'd12;
    repeat (3) tick();
    chk4("wrap_wpb", bus.write_pointer_bin, 4'd0);
    chk4("wrap_fill", bus.fill_level, 4'd4);
    chk1("wrap_empty", bus.read_empty, 1'b0);

    // Fill to full depth (binary 8, gray 1100) with read pointer at 0
    for (int b = 1; b <= 8; b++) begin
      b4 = 4'(b);
      bus.write_pointer    = b4 ^ (b4 >> 1);
      bus.read_pointer_bin = 4'(b + 12);
      tick();
    end
    repeat (3) tick();
    bus.read_pointer_bin = 4'd0;
    #1;
    chk4("full_rtw", bus.read_to_write_pointer, 4'b1100);
    chk4("full_fill", bus.fill_level, 4'd8);
    chk1("full_empty", bus.read_empty, 1'b0);
    chk1("full_aempty", bus.read_almost_empty, 1'b0);
    chk1("full_err", bus.sync_error, 1'b0);
    tick();

    // Multi-bit gray jumps
`ifdef SYNC_W2R_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    bus.write_pointer = 4'b0000;
    repeat (4) tick();
    bus.write_pointer = 4'b0011;
    repeat (4) tick();
    chk4("jump_fill", bus.fill_level, 4'd2);
    chk1("jump_err", bus.sync_error, exp_err);
    repeat (2) tick();
    chk1("jump_err_held", bus.sync_error, exp_err);

    // Asynchronous reset mid-stream
    bus.write_pointer = 4'b0101;
    repeat (4) tick();
    chk4("pre_rst_wpb", bus.write_pointer_bin, 4'd6);
    read_reset_n = 1'b0;
    #1 chk_cleared("mid_rst");
    tick();
    chk_cleared("mid_rst_hold");
    read_reset_n = 1'b1;
    tick();
    chk4("rel_rtw_e1", bus.read_to_write_pointer, 4'b0000);
    chk1("rel_adv_e1", bus.write_advance, 1'b0);
    tick();
    chk4("rel_rtw_e2", bus.read_to_write_pointer, 4'b0101);
    chk4("rel_wpb_e2", bus.write_pointer_bin, 4'd0);
    chk1("rel_adv_e2", bus.write_advance, 1'b0);
    tick();
    chk4("rel_wpb_e3", bus.write_pointer_bin, 4'd6);
    chk1("rel_adv_e3", bus.write_advance, 1'b1);
    chk4("rel_fill_e3", bus.fill_level, 4'd6);
    tick();
    chk1("rel_adv_e4", bus.write_advance, 1'b0);
    repeat (2) tick();

    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
